// File: rtl/irq_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : irq_sched                                                 |
// | Purpose  : Prioritised interrupt scheduler with a pending register,  |
// |            a two-state trap offer/ack handshake and a priority       |
// |            stack for nested handlers.                                |
// | Options  : IRQ_SCHED_NEST_EN - when defined, higher-priority lines   |
// |            preempt a running handler up to MAX_DEPTH levels; when    |
// |            undefined, only one handler runs at a time and the stack  |
// |            is not built.                                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module irq_sched #(
  parameter int MAX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] irq,
  input  logic [31:0] imr,
  input  logic        ack,
  input  logic        eoi,
  output logic        trap,
  output logic [4:0]  vector,
  output logic [3:0]  depth,
  output logic [31:0] pend,
  output logic        err
);

`ifdef IRQ_SCHED_NEST_EN
  localparam int DEPTH_CAP = MAX_DEPTH;
`else
  // Without nesting a single handler level is allowed.
  localparam int DEPTH_CAP = (MAX_DEPTH > 1) ? 1 : MAX_DEPTH;
`endif
  localparam logic [3:0] DEPTH_LIMIT = 4'(DEPTH_CAP);
  localparam logic [5:0] PRI_NONE    = 6'd32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cur_pri;

  logic [31:0] w_eligible;
  logic [4:0]  w_winner;
  logic        w_any;
  logic        w_ack_ok;
  logic        w_eoi_ok;
  logic        w_start;
  logic [31:0] w_clr;
  logic [5:0]  w_pop_pri;

  assign w_eligible = pend & imr;
  assign w_any      = |w_eligible;

  // Lowest set index of the eligible lines wins.
  always_comb begin
    w_winner = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = 5'(i);
    end
  end

  // An ack only counts while a trap is on offer; an eoi that coincides
  // with an accepted ack, or arrives with nothing in service, is dropped.
  assign w_ack_ok = ack && (r_state == OFFER);
  assign w_eoi_ok = eoi && !w_ack_ok && (depth != 4'd0);
  assign w_clr    = w_ack_ok ? (32'd1 << vector) : 32'd0;

  assign w_start  = (r_state == IDLE) && w_any &&
                    ({1'b0, w_winner} < r_cur_pri) && (depth < DEPTH_LIMIT);

`ifdef IRQ_SCHED_NEST_EN
  localparam int SW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [5:0]    r_stack [MAX_DEPTH];
  logic [SW-1:0] w_push_idx;
  logic [SW-1:0] w_pop_idx;

  assign w_push_idx = SW'(depth);
  assign w_pop_idx  = SW'(depth - 4'd1);
  assign w_pop_pri  = r_stack[w_pop_idx];

  // Save the interrupted priority when a new handler is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) r_stack[i] <= PRI_NONE;
    end else if (w_ack_ok) begin
      r_stack[w_push_idx] <= r_cur_pri;
    end
  end
`else
  // With a single level, leaving the handler always returns to "none".
  assign w_pop_pri = PRI_NONE;
`endif

  // Pending register, offer/ack state machine, nesting depth and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      trap      <= 1'b0;
      vector    <= 5'd0;
      depth     <= 4'd0;
      pend      <= 32'd0;
      err       <= 1'b0;
      r_cur_pri <= PRI_NONE;
    end else begin
      // A request arriving on the clearing edge stays pending.
      pend <= (pend & ~w_clr) | irq;

      if ((eoi && !w_eoi_ok) || (ack && (r_state == IDLE))) begin
        err <= 1'b1;
      end

      if (w_eoi_ok) begin
        depth     <= depth - 4'd1;
        r_cur_pri <= w_pop_pri;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= OFFER;
            trap    <= 1'b1;
            vector  <= w_winner;
          end
        end
        OFFER: begin
          // Vector stays latched until the core takes it, whatever
          // happens to the mask or to newer requests meanwhile.
          if (w_ack_ok) begin
            r_state   <= IDLE;
            trap      <= 1'b0;
            depth     <= depth + 4'd1;
            r_cur_pri <= {1'b0, vector};
          end
        end
        default: begin
          r_state <= IDLE;
          trap    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_irq_sched                                              |
// | Purpose  : Directed and random stimulus for irq_sched, compared      |
// |            against a queue-based model of the scheduler.             |
// | Options  : IRQ_SCHED_NEST_EN selects the nesting expectations.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_irq_sched;

`ifdef IRQ_SCHED_NEST_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] irq;
  logic [31:0] imr;
  logic        ack;
  logic        eoi;
  logic        trap;
  logic [4:0]  vector;
  logic [3:0]  depth;
  logic [31:0] pend;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Model: accepted vectors in service (innermost last), offered line.
  logic [31:0] m_pend;
  int          m_svc[$];
  int          m_off;
  int          m_vec;
  bit          m_err;

  irq_sched #(.MAX_DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .imr     (imr),
    .ack     (ack),
    .eoi     (eoi),
    .trap    (trap),
    .vector  (vector),
    .depth   (depth),
    .pend    (pend),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_trap"},   32'(trap),   32'(m_off >= 0));
    chk({tag, "_vector"}, 32'(vector), 32'(m_vec));
    chk({tag, "_depth"},  32'(depth),  32'(m_svc.size()));
    chk({tag, "_pend"},   pend,        m_pend);
    chk({tag, "_err"},    32'(err),    32'(m_err));
  endtask

  task automatic model_reset();
    m_pend = 32'd0;
    m_svc.delete();
    m_off  = -1;
    m_vec  = 0;
    m_err  = 1'b0;
  endtask

  // Predict the effect of the coming edge from the present inputs, then
  // take the edge and compare.
  task automatic tick(input string tag);
    logic [31:0] elig;
    int          win;
    int          cur;
    bit          ack_ok;
    bit          eoi_ok;
    bit          start;
    elig = m_pend & imr;
    win  = -1;
    for (int i = 31; i >= 0; i--) if (elig[i]) win = i;
    cur    = (m_svc.size() == 0) ? 32 : m_svc[$];
    ack_ok = ack && (m_off >= 0);
    eoi_ok = eoi && !ack_ok && (m_svc.size() > 0);
    if ((ack && m_off < 0) || (eoi && !eoi_ok)) m_err = 1'b1;
    start = (m_off < 0) && (win >= 0) && (win < cur) && (m_svc.size() < CAP);
    if (ack_ok) m_pend[m_off] = 1'b0;
    m_pend = m_pend | irq;
    if (eoi_ok) void'(m_svc.pop_back());
    if (ack_ok) begin
      m_svc.push_back(m_off);
      m_off = -1;
    end else if (start) begin
      m_off = win;
      m_vec = win;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    irq = 32'd0;
    ack = 1'b0;
    eoi = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    irq = 32'd0;
    imr = 32'hFFFF_FFFF;
    ack = 1'b0;
    eoi = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Single pulse: two-edge latency, vector 5, ack clears pend.
    irq = 32'd1 << 5; tick("p5_e0");
    chk("p5_no_trap_e0", 32'(trap), 32'd0);
    irq = 32'd0;      tick("p5_e1");
    chk("p5_trap", 32'(trap), 32'd1);
    chk("p5_vec", 32'(vector), 32'd5);
    ack = 1'b1;       tick("p5_ack");
    ack = 1'b0;
    chk("p5_depth", 32'(depth), 32'd1);
    chk("p5_pend5", 32'(pend[5]), 32'd0);
    eoi = 1'b1;       tick("p5_eoi");
    eoi = 1'b0;

    // Two lines together: 3 wins, 9 follows after eoi.
    irq = (32'd1 << 3) | (32'd1 << 9); tick("p39_e0");
    irq = 32'd0;      tick("p39_e1");
    chk("p39_vec3", 32'(vector), 32'd3);
    ack = 1'b1;       tick("p39_ack");
    ack = 1'b0;
    eoi = 1'b1;       tick("p39_eoi");
    eoi = 1'b0;       tick("p39_next");
    chk("p39_trap9", 32'(trap), 32'd1);
    chk("p39_vec9", 32'(vector), 32'd9);
    ack = 1'b1;       tick("p39_ack9");
    ack = 1'b0;
    eoi = 1'b1;       tick("p39_eoi9");
    eoi = 1'b0;

    // Preemption of handler 9 by line 2.
    irq = 32'd1 << 9; tick("n9_e0");
    irq = 32'd0;      tick("n9_e1");
    ack = 1'b1;       tick("n9_ack");
    ack = 1'b0;
    irq = 32'd1 << 2; tick("n2_e0");
    irq = 32'd0;      tick("n2_e1");
`ifdef IRQ_SCHED_NEST_EN
    chk("n2_trap", 32'(trap), 32'd1);
    chk("n2_vec", 32'(vector), 32'd2);
    ack = 1'b1;       tick("n2_ack");
    ack = 1'b0;
    chk("n2_depth2", 32'(depth), 32'd2);
    eoi = 1'b1;       tick("n2_eoi1");
    tick("n2_eoi2");
    eoi = 1'b0;
`else
    chk("n2_blocked", 32'(trap), 32'd0);
    eoi = 1'b1;       tick("n2_eoi9");
    eoi = 1'b0;       tick("n2_offer");
    chk("n2_vec", 32'(vector), 32'd2);
    ack = 1'b1;       tick("n2_ack");
    ack = 1'b0;
    eoi = 1'b1;       tick("n2_eoi2");
    eoi = 1'b0;
`endif
    chk("n_depth0", 32'(depth), 32'd0);
    chk("n_err0", 32'(err), 32'd0);

    // Protocol errors.
    eoi = 1'b1;       tick("e_eoi0");
    eoi = 1'b0;
    chk("e_eoi_err", 32'(err), 32'd1);
    chk("e_eoi_depth", 32'(depth), 32'd0);
    tick("e_sticky");
    do_reset("rst1");
    ack = 1'b1;       tick("e_ack_idle");
    ack = 1'b0;
    chk("e_ack_err", 32'(err), 32'd1);
    chk("e_ack_depth", 32'(depth), 32'd0);
    do_reset("rst2");

    // Fill to the depth cap, then line 0 must wait for an eoi.
    for (int k = 0; k < CAP; k++) begin
      irq = 32'd1 << (15 - k); tick("f_e0");
      irq = 32'd0;             tick("f_e1");
      ack = 1'b1;              tick("f_ack");
      ack = 1'b0;
    end
    chk("f_full", 32'(depth), 32'(CAP));
    irq = 32'd1;      tick("f0_e0");
    irq = 32'd0;
    repeat (3) tick("f0_wait");
    chk("f0_blocked", 32'(trap), 32'd0);
    chk("f0_pending", 32'(pend[0]), 32'd1);
    eoi = 1'b1;       tick("f0_eoi");
    eoi = 1'b0;       tick("f0_offer");
    chk("f0_trap", 32'(trap), 32'd1);
    chk("f0_vec", 32'(vector), 32'd0);
    ack = 1'b1;       tick("f0_ack");
    ack = 1'b0;
    eoi = 1'b1;
    repeat (CAP) tick("f_drain");
    eoi = 1'b0;

    // Asynchronous reset in the middle of an offer.
    irq = (32'd1 << 7) | (32'd1 << 20); tick("r7_e0");
    irq = 32'd0;      tick("r7_e1");
    chk("r7_vec", 32'(vector), 32'd7);
    do_reset("r7_async");
    chk("r7_trap0", 32'(trap), 32'd0);
    chk("r7_pend0", pend, 32'd0);

    // Random traffic obeying the handshake.
    for (int n = 0; n < 400; n++) begin
      irq = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      if ($urandom_range(0, 7) == 0) irq = irq | $urandom;
      imr = $urandom | $urandom;
      ack = (m_off >= 0) && ($urandom_range(0, 2) == 0);
      eoi = !ack && (m_svc.size() > 0) && ($urandom_range(0, 3) == 0);
      tick("rnd");
    end
    irq = 32'd0;
    ack = 1'b0;
    eoi = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
